chesssoc_usb_irq_in: RTL and testbench
======================================

// Module: chesssoc_usb_irq_in
// PURPOSE
//  - Avalon-MM input PIO with edge capture and interrupt. Inbound counterpart of the output PIOs in chesssoc.
//  - Samples WIDTH async status pins from the USB controller and synchronises them to clk.
//  - Latches selected edges into a sticky capture register and raises a maskable level IRQ.
//  - Nios II reads the pins and capture bits over slave s1 and clears capture bits by writing.
// PARAMETERS
//  WIDTH        1   number of input pins, 1..32
//  SYNC_STAGES  2   synchroniser flops per pin, 2..4
//  EDGE_TYPE    0   0=rising, 1=falling, 2=any edge
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous, active-low reset
//  address    in   2      word address within s1
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe
//  writedata  in   32     write data
//  read_n     in   1      active-low read strobe (qualifies nothing; reads are side-effect free)
//  in_port    in   WIDTH  asynchronous input pins
//  readdata   out  32     read data, zero wait states, combinational from address
//  irq        out  1      level interrupt to CPU, registered
// BEHAVIOUR
//  - Reset: sync chain, prev, edge_cap, irq_mask, arm_cnt and irq are all 0. readdata follows address with zeroed registers.
//  - Sync: in_port passes through SYNC_STAGES flops to give data_in. prev = data_in delayed 1 clk.
//  - Edge detection:
//    - rise = data_in & ~prev
//    - fall = ~data_in & prev
//    - any  = data_in ^ prev
//    - The term is chosen by EDGE_TYPE.
//  - Arming: arm_cnt counts 0..SYNC_STAGES+1 after reset release, then saturates.
//    - Edge detection is forced to 0 until saturated.
//    - This means a pin already high at reset release does not cause a spurious edge.
//  - Latency:
//    - in_port change -> data_in visible at address 0 after SYNC_STAGES clks.
//    - edge_cap bit set 1 clk later.
//    - irq asserted 1 clk after that.
//  - Register map (reads of bits >= WIDTH return 0):
//    - 0 data: R = data_in. Writes ignored.
//    - 1 reserved: R = 0. Writes ignored.
//    - 2 irq_mask: RW, WIDTH bits.
//    - 3 edge_cap: R = sticky captured edges. W clears bits (see CONFIGURATION).
//  - Writes take effect on the clk edge where chipselect && !write_n.
//  - irq <= |(edge_cap & irq_mask), evaluated on the registered values of both.
//    - irq stays high until all masked capture bits are cleared or masked off.
//  - Simultaneous edge and clear on the same bit in one clk: set wins, bit stays 1.
//  - Mask written 0 while the bit is captured: irq drops next clk. edge_cap is retained.
//  - Setting the mask later re-asserts irq.
//  - Edges on masked-off bits are still captured.
//  - Reset mid-operation: all state clears immediately (async). Re-arming repeats.
//  - Glitch shorter than 1 clk may be missed. No minimum pulse filtering.
// CONFIGURATION
//  - Macro USB_IRQ_BITCLEAR_EN:
//    - Defined: a write to address 3 clears only the edge_cap bits where writedata = 1.
//    - Undefined: any write to address 3 clears all edge_cap bits; writedata is ignored.
// TESTING
//  1 Reset, in_port=1 held through release, EDGE_TYPE=0, mask=1 -> edge_cap stays 0, irq stays 0 for 20 clks.
//  2 WIDTH=4, mask=4'hF, in_port 0->4'b0101 -> read addr 0 = 5 after SYNC_STAGES clks.
//    Then edge_cap = 5 one clk later, irq=1 one clk after that.
//  3 BITCLEAR_EN defined, edge_cap=5, write addr 3 = 4 -> edge_cap=1, irq stays 1. Write 1 -> edge_cap=0, irq=0 next clk.
//  4 BITCLEAR_EN undefined, edge_cap=5, write addr 3 = 0 -> edge_cap=0, irq falls next clk.
//  5 Rising edge on bit0 lands in the same clk as a clear write of bit0 -> edge_cap[0]=1, irq stays 1.
//  6 EDGE_TYPE=2, mask=0: pulse bit1 high for 3 clks -> edge_cap=2, irq=0.
//    Then write mask=2 -> irq=1 next clk. Read addr 1 = 0, read addr 2 = 2.

Source files
------------

// File: rtl/chesssoc_usb_irq_in_if.sv
// Avalon-MM slave bus bundle for the chesssoc USB interrupt-input PIO (slave s1).
interface chesssoc_usb_irq_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        read_n;
    logic [31:0] readdata;

    modport slave (
        input  address, chipselect, write_n, writedata, read_n,
        output readdata
    );

    modport master (
        output address, chipselect, write_n, writedata, read_n,
        input  readdata
    );
endinterface

// File: rtl/chesssoc_usb_irq_in.sv
// Avalon-MM input PIO: synchronises USB status pins, captures edges, raises a maskable IRQ.
// Optional macro USB_IRQ_BITCLEAR_EN: edge_cap writes clear only the bits written as 1.
module chesssoc_usb_irq_in #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    chesssoc_usb_irq_in_if.slave  s1,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [2:0]       arm_cnt_q, arm_cnt_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic             armed;
    logic             wr_en;
    logic             unused_ok;

    assign data_in = sync_q[SYNC_STAGES-1];
    assign armed   = (arm_cnt_q == ARM_MAX);

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_raw = data_in & ~prev_q;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_raw = ~data_in & prev_q;
        end else begin : g_any
            assign edge_raw = data_in ^ prev_q;
        end
    endgenerate

    // Held off until the chain has flushed, so pins already high at reset release look static.
    assign edge_det = armed ? edge_raw : '0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
        wr_en      = s1.chipselect && !s1.write_n;
        cap_clr    = '0;
        irq_mask_d = irq_mask_q;
        if (wr_en && s1.address == 2'd3) begin
`ifdef USB_IRQ_BITCLEAR_EN
            cap_clr = s1.writedata[WIDTH-1:0];
`else
            cap_clr = '1;
`endif
        end
        if (wr_en && s1.address == 2'd2) begin
            irq_mask_d = s1.writedata[WIDTH-1:0];
        end
        // Set is OR-ed in after the clear, so a coincident edge wins.
        edge_cap_d = (edge_cap_q & ~cap_clr) | edge_det;
        irq_d      = |(edge_cap_q & irq_mask_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the synchroniser array is reset too; the arming count relies on it starting at 0.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            arm_cnt_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q     <= data_in;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            arm_cnt_q  <= arm_cnt_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        s1.readdata = '0;
        case (s1.address)
            2'd0:    s1.readdata[WIDTH-1:0] = data_in;
            2'd2:    s1.readdata[WIDTH-1:0] = irq_mask_q;
            2'd3:    s1.readdata[WIDTH-1:0] = edge_cap_q;
            default: s1.readdata = '0;
        endcase
    end

    assign irq = irq_q;

    // read_n qualifies nothing and upper writedata bits may be beyond WIDTH.
    assign unused_ok = ^{s1.read_n, s1.writedata};

endmodule

// File: tb/tb_chesssoc_usb_irq_in.sv
// Bench for chesssoc_usb_irq_in: three instances (rise/fall/any, 2/3/4 sync stages) vs a history-based model.
module tb_chesssoc_usb_irq_in;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        read_n;
    logic [3:0]  in_port;

    logic [N-1:0]       irq_w;
    logic [N-1:0][31:0] rd_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        chesssoc_usb_irq_in_if bus ();
        assign bus.address    = address;
        assign bus.chipselect = chipselect;
        assign bus.write_n    = write_n;
        assign bus.writedata  = writedata;
        assign bus.read_n     = read_n;
        assign rd_w[k]        = bus.readdata;

        chesssoc_usb_irq_in #(
            .WIDTH       (4),
            .SYNC_STAGES (k + 2),
            .EDGE_TYPE   (k)
        ) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .s1      (bus.slave),
            .in_port (in_port),
            .irq     (irq_w[k])
        );
    end

    // Reference model: in_hist holds in_port as sampled at every clock edge since reset release.
    logic [3:0] in_hist [$];
    logic [3:0] m_cap [N];
    logic       m_irq [N];
    logic [3:0] m_mask;

    // Pin value visible at data_in after n edges for an s-stage synchroniser.
    function automatic logic [3:0] d_at(int s, int n);
        if (n < s) return 4'h0;
        return in_hist[n - s];
    endfunction

    function automatic logic [31:0] m_read(int k);
        case (address)
            2'd0:    return {28'h0, d_at(k + 2, in_hist.size())};
            2'd2:    return {28'h0, m_mask};
            2'd3:    return {28'h0, m_cap[k]};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_hist.delete();
            m_mask = 4'h0;
            for (int k = 0; k < N; k++) begin
                m_cap[k] = 4'h0;
                m_irq[k] = 1'b0;
            end
        end else begin
            int         n;
            logic       wr;
            logic [3:0] clr, e, cur, pv;
            n   = in_hist.size();
            wr  = chipselect && !write_n;
            clr = 4'h0;
            if (wr && address == 2'd3) begin
`ifdef USB_IRQ_BITCLEAR_EN
                clr = writedata[3:0];
`else
                clr = 4'hF;
`endif
            end
            for (int k = 0; k < N; k++) begin
                e = 4'h0;
                if (n >= k + 3) begin
                    cur = d_at(k + 2, n);
                    pv  = d_at(k + 2, n - 1);
                    case (k)
                        0:       e = cur & ~pv;
                        1:       e = ~cur & pv;
                        default: e = cur ^ pv;
                    endcase
                end
                m_irq[k] = |(m_cap[k] & m_mask);
                m_cap[k] = (m_cap[k] & ~clr) | e;
            end
            if (wr && address == 2'd2) m_mask = writedata[3:0];
            in_hist.push_back(in_port);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("irq[%0d]", k), {31'h0, irq_w[k]}, {31'h0, m_irq[k]});
            check($sformatf("rd[%0d]@%0d", k, address), rd_w[k], m_read(k));
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic cs, input logic wn,
                         input logic [31:0] wd, input logic [3:0] ip);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        in_port    = ip;
        read_n     = !(cs && wn);
    endtask

    task automatic idle(input int cycles, input logic [1:0] a, input logic [3:0] ip);
        for (int i = 0; i < cycles; i++) begin
            drive(a, 1'b0, 1'b1, 32'h0, ip);
            wait_neg();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(2'd0, 1'b0, 1'b1, 32'h0, 4'hF);
        wait_neg();
        wait_neg();
        check("reset_rd0", rd_w[0], 32'h0);
        check("reset_irq", {29'h0, irq_w}, 32'h0);

        // Pins high through reset release must not produce an edge.
        reset_n = 1'b1;
        drive(2'd2, 1'b1, 1'b0, 32'hF, 4'hF);
        wait_neg();
        drive(2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            wait_neg();
            check("t1_cap", rd_w[0], 32'h0);
            check("t1_irq", {31'h0, irq_w[0]}, 32'h0);
        end

        // Settle pins low and clear everything before the latency test.
        idle(7, 2'd3, 4'h0);
        drive(2'd3, 1'b1, 1'b0, 32'hF, 4'h0);
        wait_neg();
        idle(2, 2'd0, 4'h0);

        // Latency: data after SYNC_STAGES, capture one later, irq one after that.
        drive(2'd0, 1'b0, 1'b1, 32'h0, 4'h5);
        wait_neg();
        check("t2_data_early", rd_w[0], 32'h0);
        wait_neg();
        check("t2_data", rd_w[0], 32'h5);
        drive(2'd3, 1'b0, 1'b1, 32'h0, 4'h5);
        wait_neg();
        check("t2_cap", rd_w[0], 32'h5);
        check("t2_irq_early", {31'h0, irq_w[0]}, 32'h0);
        wait_neg();
        check("t2_irq", {31'h0, irq_w[0]}, 32'h1);

        // Clear write of 4 with edge_cap = 5.
        drive(2'd3, 1'b1, 1'b0, 32'h4, 4'h5);
        wait_neg();
`ifdef USB_IRQ_BITCLEAR_EN
        check("t3_cap", rd_w[0], 32'h1);
`else
        check("t4_cap", rd_w[0], 32'h0);
`endif
        check("t3_irq_hold", {31'h0, irq_w[0]}, 32'h1);
        idle(1, 2'd3, 4'h5);
`ifdef USB_IRQ_BITCLEAR_EN
        check("t3_irq_stays", {31'h0, irq_w[0]}, 32'h1);
        drive(2'd3, 1'b1, 1'b0, 32'h1, 4'h5);
        wait_neg();
        check("t3_cap_zero", rd_w[0], 32'h0);
        idle(1, 2'd3, 4'h5);
`endif
        check("t34_irq_fall", {31'h0, irq_w[0]}, 32'h0);

        // Edge and clear of bit0 on the same clock: set wins.
        idle(7, 2'd3, 4'h0);
        drive(2'd3, 1'b1, 1'b0, 32'hF, 4'h0);
        wait_neg();
        idle(2, 2'd3, 4'h0);
        idle(2, 2'd3, 4'h1);
        drive(2'd3, 1'b1, 1'b0, 32'h1, 4'h1);
        wait_neg();
        check("t5_cap", rd_w[0], 32'h1);
        idle(1, 2'd3, 4'h1);
        check("t5_irq", {31'h0, irq_w[0]}, 32'h1);

        // Any-edge instance, masked off: a 3-clock pulse captures without irq.
        idle(8, 2'd3, 4'h0);
        drive(2'd2, 1'b1, 1'b0, 32'h0, 4'h0);
        wait_neg();
        drive(2'd3, 1'b1, 1'b0, 32'hF, 4'h0);
        wait_neg();
        idle(3, 2'd3, 4'h2);
        idle(8, 2'd3, 4'h0);
        check("t6_cap", rd_w[2], 32'h2);
        check("t6_irq_masked", {31'h0, irq_w[2]}, 32'h0);
        drive(2'd2, 1'b1, 1'b0, 32'h2, 4'h0);
        wait_neg();
        idle(1, 2'd1, 4'h0);
        check("t6_irq", {31'h0, irq_w[2]}, 32'h1);
        check("t6_rsvd", rd_w[2], 32'h0);
        idle(1, 2'd2, 4'h0);
        check("t6_mask", rd_w[2], 32'h2);

        // Randomised traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] ip;
            ip = ($urandom_range(0, 2) == 0) ? 4'($urandom) : in_port;
            drive(2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), $urandom, ip);
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                wait_neg();
                wait_neg();
                check("mid_reset_irq", {29'h0, irq_w}, 32'h0);
                reset_n = 1'b1;
            end else begin
                wait_neg();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
